// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle RV32 sequencer owning pc/ir, memory handshakes and
// the writeback/trap strobes, one instruction at a time.
module core_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ir,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        branch_taken,
    input  logic [31:0] target,
    input  logic [31:0] trap_vec,
    input  logic [31:0] epc,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    output logic        rf_we,
    output logic        csr_we,
    output logic        exc_take,
    output logic        halt,
    output logic        bus_err,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {FETCH, IWAIT, DECODE, EXEC, MEM, MWAIT, WB, HALT} state_t;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    state_t      st, nst;
    logic [7:0]  cnt;
    logic [31:0] npc;
    logic        is_load, is_store, is_csr, rf_op, waiting, misal, tmo;
    assign is_load  = opcode == 7'b0000011;
    assign is_store = opcode == 7'b0100011;
    assign is_csr   = opcode == 7'b1110011 && funct3 != 3'd0;
    assign rf_op    = is_csr || opcode inside {7'b0110011, 7'b0010011, 7'b0000011,
                      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    assign npc = ir == ECALL ? trap_vec :
                 ir == MRET ? epc :
                 opcode == 7'b1101111 ? target :
                 opcode == 7'b1100111 ? {target[31:1], 1'b0} :
                 (opcode == 7'b1100011 && branch_taken) ? target : pc + 32'd4;
    assign misal   = st == WB && npc[1];
    assign waiting = st inside {FETCH, IWAIT, MEM, MWAIT};
    always_comb begin
        nst = st;
        case (st)
            FETCH:   nst = imem_ready ? IWAIT : FETCH;
            IWAIT:   nst = imem_rvalid ? DECODE : IWAIT;
            DECODE:  nst = EXEC;
            EXEC:    nst = (is_load || is_store) ? MEM : ir == EBREAK ? HALT : WB;
            MEM:     nst = dmem_ready ? (is_store ? WB : MWAIT) : MEM;
            MWAIT:   nst = dmem_rvalid ? WB : MWAIT;
            WB:      nst = npc[1] ? HALT : FETCH;
            default: nst = HALT;
        endcase
        // still stalled after TIMEOUT counted cycles: give up on the bus
        tmo = waiting && nst == st && cnt == TIMEOUT;
        if (tmo) nst = HALT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= FETCH;
            pc      <= RESET_PC;
            ir      <= NOP;
            cnt     <= 8'd0;
            bus_err <= 1'b0;
        end else begin
            st  <= nst;
            cnt <= nst != st ? 8'd0 : waiting ? cnt + 8'd1 : cnt;
            if (st == IWAIT && imem_rvalid) ir <= imem_rdata;
            if (st == WB && !npc[1]) pc <= npc;
            if (misal || tmo) bus_err <= 1'b1;
        end
    end
    assign imem_req = st == FETCH;
    assign dmem_req = st == MEM;
    assign dmem_we  = st == MEM && is_store;
    assign rf_we    = st == WB && rf_op;
    assign csr_we   = st == WB && is_csr;
    assign exc_take = st == WB && ir == ECALL;
    assign halt     = st == HALT;
    assign state    = st;
endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
Multi-cycle sequencer for the RV32 core. It owns the PC and the instruction register (IR) and drives the instruction-memory and data-memory handshakes. The IR feeds the combinational instruction decoder, whose opcode/funct3 outputs return here to pick the next state. It issues the register-file write, CSR write, trap and PC-update strobes, one instruction at a time.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
TIMEOUT, 255, maximum wait cycles in a memory-wait state before bus_err (counter is 8 bits wide).

Ports:
clk  in  1  clock
rst  in  1  reset
imem_req  out  1  fetch request; address is pc
imem_ready  in  1  imem accepts the request this cycle
imem_rvalid  in  1  fetch data valid
imem_rdata  in  32  fetched instruction
pc  out  32  current PC
ir  out  32  instruction register, drives the decoder
opcode  in  7  from decoder
funct3  in  3  from decoder
branch_taken  in  1  branch compare result from the ALU
target  in  32  jump/branch target from the datapath
trap_vec  in  32  mtvec value from the CSR file
epc  in  32  mepc value from the CSR file
dmem_req  out  1  data request
dmem_we  out  1  1 = store
dmem_ready  in  1  dmem accepts the request
dmem_rvalid  in  1  load data valid
rf_we  out  1  register-file write strobe, 1 cycle
csr_we  out  1  CSR write strobe, 1 cycle
exc_take  out  1  ecall pulse; CSR file latches mepc=pc, mcause=11
halt  out  1  sticky; set by ebreak or error
bus_err  out  1  sticky; set by timeout or misaligned target
state  out  3  FSM state, for debug

Behaviour:
- Everything is synchronous to rising clk. When rst=1: state=FETCH, pc=RESET_PC, ir=32'h0000_0013, wait counter=0. All strobes, halt and bus_err are 0. This holds also when rst rises mid-transaction; any outstanding memory response is then ignored.
- State encoding: FETCH=0, IWAIT=1, DECODE=2, EXEC=3, MEM=4, MWAIT=5, WB=6, HALT=7.
- FETCH: imem_req=1. When imem_ready=1, go to IWAIT; imem_req is 0 from the next cycle.
- IWAIT: when imem_rvalid=1, ir<=imem_rdata and go to DECODE. imem_rvalid in any other state is ignored.
- DECODE: one cycle; the decoder settles on ir. Go to EXEC.
- EXEC: one cycle.
  - opcode 0000011 (load) or 0100011 (store): go to MEM.
  - ir==32'h0010_0073 (ebreak): go to HALT, halt=1.
  - Otherwise go to WB.
- MEM: dmem_req=1, dmem_we=(opcode==0100011). On dmem_ready: a store goes to WB; a load goes to MWAIT.
- MWAIT: on dmem_rvalid, go to WB.
- WB: one cycle, then FETCH.
  - rf_we=1 when opcode is in {0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111}, or opcode==1110011 with funct3!=0.
  - csr_we=1 when opcode==1110011 and funct3!=0.
  - PC update, first match wins:
    - ir==32'h0000_0073 (ecall): pc<=trap_vec, exc_take=1.
    - ir==32'h3020_0073 (mret): pc<=epc.
    - opcode 1101111 (jal): pc<=target.
    - opcode 1100111 (jalr): pc<={target[31:1],1'b0}.
    - opcode 1100011 with branch_taken=1: pc<=target.
    - Otherwise pc<=pc+4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
  - If the selected new pc has bit 1 set: pc is not updated, bus_err=1, halt=1, go to HALT; rf_we and csr_we still fire that cycle.
- Wait counter: cleared on every state change. It increments each cycle spent in FETCH, IWAIT, MEM or MWAIT. When it reaches TIMEOUT while still waiting: bus_err=1, halt=1, go to HALT.
- HALT: absorbing until rst. No requests or strobes are issued; pc and ir hold.
- Strobes (rf_we, csr_we, exc_take) are combinational from the state and are asserted only in WB.
- Zero-wait memory (imem_ready in FETCH, imem_rvalid the next cycle): a non-memory instruction takes 5 cycles, a load 7, a store 6.

Test Plan:
1. Reset → pc=32'h8000_0000, ir=32'h0000_0013, state=0, imem_req=1 in the first cycle after rst drops, all strobes 0.
2. Zero-wait fetch of addi x1,x0,5 (32'h0050_0093) → rf_we high exactly in cycle 4 after leaving reset, pc=32'h8000_0004 in cycle 5, imem_req reasserted.
3. beq (32'h0000_0463) with branch_taken=1, target=32'h8000_0010 → rf_we=0 in WB, pc=32'h8000_0010. Repeat with branch_taken=0 → pc=pc+4.
4. lw (32'h0000_2083) with dmem_ready delayed 3 cycles and dmem_rvalid 2 cycles later → dmem_req held 4 cycles with dmem_we=0, rf_we pulses once, 11 cycles total.
5. ecall with trap_vec=32'h8000_0100 → exc_take=1 for 1 cycle, pc=32'h8000_0100. Then ebreak → halt=1, no further imem_req.
6. imem_rvalid never arrives → bus_err=1 and halt=1 after 255 wait cycles in IWAIT, state=7. jalr with target=32'h8000_0006 → bus_err=1, pc unchanged.
